// File: rtl/key_expand_ctrl_192_pkg.sv
// Shared sizes and FSM state type for the AES-192 key schedule controller.
package aes192_pkg;
  localparam int NK       = 6;
  localparam int NR       = 12;
  localparam int NUM_RK   = 13;
  localparam int NUM_ITER = 8;
  localparam int RK_W     = 128;
  localparam int KEY_W    = 192;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } state_t;
endpackage

// File: rtl/key_expand_ctrl_192_if.sv
// Key load handshake and round-key read port of the AES-192 key schedule controller.
interface key_expand_ctrl_192_if;
  import aes192_pkg::*;

  logic [KEY_W-1:0] key_in;
  logic             key_valid;
  logic             key_ready;
  logic             keys_valid;
  logic [3:0]       rk_idx;
  logic [RK_W-1:0]  rk_out;

  modport master (
    output key_in, key_valid, rk_idx,
    input  key_ready, keys_valid, rk_out
  );

  modport slave (
    input  key_in, key_valid, rk_idx,
    output key_ready, keys_valid, rk_out
  );
endinterface

// File: rtl/key_expand_ctrl_192_expand.sv
// One AES-192 schedule iteration: six new words from the previous six.
module expand_single_round (
  input  logic [3:0]   round_no,
  input  logic [191:0] before_ex,
  output logic [191:0] after_ex
);
  logic [31:0] w0, w1, w2, w3, w4, w5;
  logic [31:0] rot, sub;
  logic [31:0] n0, n1, n2, n3, n4, n5;
  logic [7:0]  rc;

  assign {w0, w1, w2, w3, w4, w5} = before_ex;

  rotate_word u_rot (.word_in(w5), .word_out(rot));
  sbox u_sb3 (.byte_in(rot[31:24]), .byte_out(sub[31:24]));
  sbox u_sb2 (.byte_in(rot[23:16]), .byte_out(sub[23:16]));
  sbox u_sb1 (.byte_in(rot[15:8]),  .byte_out(sub[15:8]));
  sbox u_sb0 (.byte_in(rot[7:0]),   .byte_out(sub[7:0]));
  rcon u_rcon (.round_no(round_no), .rcon_byte(rc));

  assign n0 = w0 ^ sub ^ {rc, 24'h000000};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign n4 = w4 ^ n3;
  assign n5 = w5 ^ n4;

  // Round 0 marks the idle expander; force zeros so nothing stale leaks out.
  assign after_ex = (round_no == 4'd0) ? '0 : {n0, n1, n2, n3, n4, n5};
endmodule

// File: rtl/key_expand_ctrl_192_rk_store_192.sv
// Nine 192-bit schedule stages plus the registered 13-way round-key read mux.
module rk_store_192
  import aes192_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [3:0]       wr_sel,
  input  logic [KEY_W-1:0] wr_data,
  input  logic [3:0]       prev_sel,
  output logic [KEY_W-1:0] prev_data,
  input  logic [3:0]       rk_idx,
  output logic [RK_W-1:0]  rk_out
);
  localparam int NUM_STAGES = NUM_ITER + 1;
  localparam int STREAM_W   = NUM_STAGES * KEY_W;

  logic [KEY_W-1:0]    stage [NUM_STAGES];
  logic [STREAM_W-1:0] stream;
  logic [RK_W-1:0]     rk_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_STAGES; k++) stage[k] <= '0;
      rk_out <= '0;
    end else begin
      if (wr_en) begin
        for (int k = 0; k < NUM_STAGES; k++) begin
          if (wr_sel == 4'(k)) stage[k] <= wr_data;
        end
      end
      rk_out <= rk_next;
    end
  end

  // Word stream S0..S8 with w0 in the top bits, so round key i starts 4*i words down.
  always_comb begin
    stream = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      stream[STREAM_W - KEY_W*(k+1) +: KEY_W] = stage[k];
    end
  end

  always_comb begin
    prev_data = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (prev_sel == 4'(k)) prev_data = stage[k];
    end
  end

  always_comb begin
    rk_next = '0;
    for (int i = 0; i < NUM_RK; i++) begin
      if (rk_idx == 4'(i)) rk_next = stream[STREAM_W - RK_W*(i+1) +: RK_W];
    end
  end
endmodule

// File: rtl/key_expand_ctrl_192_sbox.sv
// AES S-box, word rotation and round constant used by the shared round expander.
module sbox (
  input  logic [7:0] byte_in,
  output logic [7:0] byte_out
);
  // Byte 0x00 sits in the top bits, so entry n lives at bit offset (255-n)*8.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] base;

  assign base     = {~byte_in, 3'b000};
  assign byte_out = SBOX_TABLE[base +: 8];
endmodule

module rotate_word (
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);
  assign word_out = {word_in[23:0], word_in[31:24]};
endmodule

module rcon (
  input  logic [3:0] round_no,
  output logic [7:0] rcon_byte
);
  always_comb begin
    rcon_byte = 8'h00;
    case (round_no)
      4'd1:    rcon_byte = 8'h01;
      4'd2:    rcon_byte = 8'h02;
      4'd3:    rcon_byte = 8'h04;
      4'd4:    rcon_byte = 8'h08;
      4'd5:    rcon_byte = 8'h10;
      4'd6:    rcon_byte = 8'h20;
      4'd7:    rcon_byte = 8'h40;
      4'd8:    rcon_byte = 8'h80;
      default: rcon_byte = 8'h00;
    endcase
  end
endmodule

// File: rtl/key_expand_ctrl_192.sv
// AES-192 decryption key schedule controller: one shared expander stepped over eight cycles.
module key_expand_ctrl_192
  import aes192_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  key_expand_ctrl_192_if.slave bus
);
  state_t           state, next_state;
  logic [3:0]       cnt, next_cnt;
  logic             load, expanding;
  logic             key_ready, keys_valid;
  logic             wr_en;
  logic [3:0]       wr_sel, exp_round, prev_sel;
  logic [KEY_W-1:0] wr_data, prev_stage, exp_out;
  logic [RK_W-1:0]  rk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    load       = 1'b0;
    expanding  = 1'b0;
    key_ready  = 1'b0;
    keys_valid = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (bus.key_valid) begin
          load       = 1'b1;
          next_cnt   = 4'd1;
          next_state = EXPAND;
        end
      end
      EXPAND: begin
        expanding = 1'b1;
        if (cnt == 4'(NUM_ITER)) begin
          next_cnt   = 4'd0;
          next_state = READY;
        end else begin
          next_cnt = cnt + 4'd1;
        end
      end
      READY: begin
        key_ready  = 1'b1;
        keys_valid = 1'b1;
        if (bus.key_valid) begin
          load       = 1'b1;
          next_cnt   = 4'd1;
          next_state = EXPAND;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = 4'd0;
      end
    endcase
  end

  // Outside EXPAND cnt is 0, so prev_sel wraps to 15 and the store returns zeros.
  assign prev_sel  = cnt - 4'd1;
  assign exp_round = expanding ? cnt : 4'd0;
  assign wr_en     = load | expanding;
  assign wr_sel    = load ? 4'd0 : cnt;
  assign wr_data   = load ? bus.key_in : exp_out;

  expand_single_round u_expand (
    .round_no (exp_round),
    .before_ex(prev_stage),
    .after_ex (exp_out)
  );

  rk_store_192 u_store (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .prev_sel (prev_sel),
    .prev_data(prev_stage),
    .rk_idx   (bus.rk_idx),
    .rk_out   (rk_q)
  );

  assign bus.key_ready  = key_ready;
  assign bus.keys_valid = keys_valid;
  assign bus.rk_out     = rk_q;
endmodule

// File: doc/key_expand_ctrl_192.md
# key_expand_ctrl_192

Sequential controller for the AES-192 decryption key schedule. It accepts a 192-bit cipher key and steps one shared `expand_single_round` instance through its 8 expansion iterations, one per clock. It stores the resulting 52 schedule words and serves any of the 13 round keys to the decrypt round datapath by index. The decrypt datapath reads indices 12 down to 0.

## Interface
- Parameters: none. All sizes are fixed by AES-192 and come from the shared package.
- `clk  in  1` — single clock; all state updates on the rising edge.
- `rst  in  1` — asynchronous, active-high reset.
- `key_in  in  192` — cipher key. Word w0 = `key_in[191:160]` … w5 = `key_in[31:0]`. Same word packing as `expand_single_round`.
- `key_valid  in  1` — a key is offered on `key_in`.
- `key_ready  out  1` — the block can accept a key this cycle.
- `keys_valid  out  1` — all 13 round keys for the last accepted key are stored and stable.
- `rk_idx  in  4` — round-key index, 0..12.
- `rk_out  out  128` — round key `rk_idx`, registered, one cycle after `rk_idx`. Round key i = {w(4i), w(4i+1), w(4i+2), w(4i+3)}, with w(4i) in bits [127:96].

## Operation
- **Storage:** 9 stage registers of 192 bits. S0 = key. Sk = `expand_single_round(round_no=k, before_ex=S(k-1))` for k = 1..8. The word stream is S0‖S1‖…‖S8 (54 words). Words w52 and w53 are never addressed.
- **FSM states:** IDLE, EXPAND, READY.
  - **IDLE:** `key_ready`=1, `keys_valid`=0. If `key_valid`, then S0←`key_in`, `cnt`←1, go to EXPAND.
  - **EXPAND:** `key_ready`=0, `keys_valid`=0. Each cycle: S[`cnt`]←expand(S[`cnt`-1], `cnt`), `cnt`←`cnt`+1. When `cnt`==8, write S8 and go to READY. `key_valid` is ignored (no accept).
  - **READY:** `key_ready`=1, `keys_valid`=1. If `key_valid`, load as in IDLE, `keys_valid`←0 at that edge, go to EXPAND. A new key overwrites the schedule; there is no double buffering.
- **Shared expander:** exactly one `expand_single_round` instance.
  - Its `round_no` input is `cnt` (4 bits, 1..8) and its `before_ex` input is S[`cnt`-1].
  - Outside EXPAND it is driven with `round_no`=0. Its output is then all-zero and is never written.
- **Round-key read:** `rk_out` ← slice of the word stream selected by `rk_idx`, registered every cycle in every state.
  - `rk_idx` 13..15 → `rk_out` = 0.
  - During EXPAND, `rk_out` reflects the current, partially written store. Consumers must gate on `keys_valid`.
- **`cnt`:** 4-bit, range 1..8 inside EXPAND, 0 otherwise. It never wraps.

## Timing
- **Reset values:**
  - state=IDLE, `cnt`=0, S0..S8=0.
  - `key_ready`=1 (combinational from state), `keys_valid`=0, `rk_out`=0.
- **Key acceptance:** a key is accepted on an edge where `key_valid`&&`key_ready` (edge E0).
- **Expansion:** S1..S8 are written on edges E1..E8. `keys_valid` goes high after E8 and `key_ready` goes high at the same time. Accept-to-valid latency is 8 cycles.
- **Back-to-back keys:** `key_valid` held high in READY is accepted immediately, giving one key every 9 cycles.
- **Read latency:** `rk_idx` applied before edge N → `rk_out` valid after edge N. `rk_idx` may change every cycle.
- **Reset mid-EXPAND:** asynchronous return to IDLE, store cleared, `keys_valid`=0 immediately, with no partial completion. Reset deassertion is synchronous to `clk` at the system level.
- **Accept coinciding with a read in READY:** the read issued that cycle returns the old schedule. Reads issued after the accept edge return new or partial data.

## Structure
- **Package `aes192_pkg`:**
  - Constants: NK=6, NR=12, NUM_RK=13, NUM_ITER=8, RK_W=128, KEY_W=192.
  - `state_t` enum {IDLE, EXPAND, READY}.
- **Sub-modules:**
  - Reuse `expand_single_round` unchanged, together with its `rotate_word`, `sbox` and `rcon` children.
  - One new sub-module is natural: `rk_store_192`, holding the 9×192 register file and the registered 13-way 128-bit read mux. The FSM and `cnt` stay in the top.

## Test plan
- **Round key 0:** reset, then accept FIPS-197 A.2 key `8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b`.
  - `keys_valid` rises exactly 8 cycles after the accept edge.
  - `rk_idx`=0 → `8e73b0f7da0e6452c810f32b809079e5`.
- **Round key 1:** same key, `rk_idx`=1 → `62f8ead2522c6b7bfe0c91f72402f5a5` (checks the first expander write, w6=`fe0c91f7`).
- **Round key 12 and reverse sweep:**
  - Same key, `rk_idx`=12 → `e98ba06f448c773c8ecc720401002202`.
  - Sweep `rk_idx` 12→0 on consecutive cycles; every output matches the golden model with 1-cycle latency.
  - `rk_idx`=13 → 0.
- **Handshake:**
  - `key_valid` held high throughout: accepts exactly every 9 cycles, and `key_ready` is low for exactly 8 cycles after each accept.
  - A second key offered during EXPAND is not accepted.
- **Async reset at E4:** assert `rst` between E3 and E4.
  - Immediately: `keys_valid`=0, `key_ready`=1.
  - After deassert: `rk_out`=0 for every index.
  - A fresh key then completes in 8 cycles with the correct round keys.
- **Key replacement in READY:** accept an all-zero key while READY.
  - `keys_valid` falls on the accept edge.
  - After completion, `rk_idx`=12 → the all-zero AES-192 round key 12 from the golden model.
